hwpe_stream_fifo_scm_ctrl: RTL and testbench
============================================

HWPE_STREAM_FIFO_SCM_CTRL -- requirements
Module: hwpe_stream_fifo_scm_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ALMOST_FULL_THR, default 6, meaning level at or above which almost_full_o is asserted (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all flops use its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port clear_i, input, 1, meaning synchronous flush.
REQ-007 SHALL have ports push_valid_i (input, 1), push_data_i (input, DATA_WIDTH) and push_ready_o (output, 1), meaning the upstream stream.
REQ-008 SHALL have ports pop_valid_o (output, 1), pop_data_o (output, DATA_WIDTH) and pop_ready_i (input, 1), meaning the downstream stream.
REQ-009 SHALL have ports empty_o (output, 1) and full_o (output, 1), meaning occupancy == 0 and occupancy == DEPTH.

Function
REQ-010 SHALL transfer on either port only in a cycle where valid and ready are both high at the rising edge.
REQ-011 SHALL drive push_ready_o = !full_o, derived from registered occupancy only; there is no same-cycle push bypass when full, even if a pop occurs in that cycle.
REQ-012 SHALL count occupancy (ADDR_WIDTH+1 bits) from push handshake until pop handshake, so the entry presented on pop_data_o still occupies its slot; capacity is exactly DEPTH.
REQ-013 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH bits, increment each by one per write or read issue, and let them wrap naturally from DEPTH-1 to 0.
REQ-014 SHALL assert SCM WriteEnable with WriteAddr = wr_ptr and WriteData = push_data_i in the push handshake cycle.
REQ-015 SHALL make an entry pushed in cycle k eligible for read issue no earlier than cycle k+1, which keeps the latch write phase off the read path.
REQ-016 SHALL issue a read (ReadEnable=1, ReadAddr=rd_ptr) in any cycle where an eligible unread entry exists and (!pop_valid_o or pop handshake).
REQ-017 SHALL drive pop_data_o directly from SCM ReadData; ReadData holds while ReadEnable=0 and no output register is added.
REQ-018 SHALL set pop_valid_o next = 1 on read issue, else 0 on pop handshake, else hold.
REQ-019 SHALL give push-to-pop latency such that a push in cycle k into an empty FIFO raises pop_valid_o in cycle k+2, with sustained throughput of one transfer per cycle in each direction.
REQ-020 SHALL, on a push and pop in the same cycle, leave occupancy unchanged; a push to an empty FIFO in the same cycle as pop_ready_i=1 does not pop.
REQ-021 SHALL keep pop_data_o stable while pop_valid_o=1 and pop_ready_i=0.
REQ-022 SHALL never overwrite the slot currently addressed for read; REQ-011 and REQ-012 guarantee this.
REQ-023 SHALL, on clear_i=1, zero pointers, occupancy, eligibility state and pop_valid_o at the next edge; it ignores a handshake in the same cycle and leaves memory contents untouched.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously zero wr_ptr, rd_ptr, occupancy and eligibility state, and set pop_valid_o=0, empty_o=1, full_o=0, push_ready_o=1.
REQ-025 SHALL leave pop_data_o undefined after reset until the first pop_valid_o=1, because SCM address and data registers are not reset.
REQ-026 SHALL, on reset asserted mid-transfer, drop all entries, including writes in flight.

Configuration
REQ-027 SHALL, with HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN defined, add ports level_o (output, ADDR_WIDTH+1, the occupancy, reset 0) and almost_full_o (output, 1, occupancy >= ALMOST_FULL_THR, reset 0).
REQ-028 SHALL, without HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN, omit both ports and the ALMOST_FULL_THR comparator, with all other behaviour identical.

Structure
REQ-029 SHALL instantiate exactly one sub-module, hwpe_stream_fifo_scm (ADDR_WIDTH, DATA_WIDTH), connected to the same clk and rst_n.
REQ-030 SHALL place typedef hwpe_stream_fifo_flags_t {empty, full, almost_full} in hwpe_stream_package, used for the internal flag bundle.
REQ-031 SHALL use no other package additions; all other constants are local.

Verification
REQ-032 SHALL cover: reset, then push 0xA5A5A5A5 in cycle 0 -> pop_valid_o=1 in cycle 2 with pop_data_o=0xA5A5A5A5, and empty_o=0 from cycle 1.
REQ-033 SHALL cover: with DEPTH=8, 8 back-to-back pushes of 0..7 with pop_ready_i=0 -> full_o=1 and push_ready_o=0 after the 8th; a 9th push_valid_i is not accepted.
REQ-034 SHALL cover: from full, push_valid_i=1 and pop_ready_i=1 held for 20 cycles -> pop output 0..7 then pushed values in order, one pop per cycle after refill, and no overwrite of the held slot.
REQ-035 SHALL cover: 3 wraps of random data with random valid/ready -> scoreboard matches in order, and pop_data_o is stable while stalled.
REQ-036 SHALL cover: clear_i pulse with occupancy 5 -> next cycle empty_o=1 and pop_valid_o=0, and the next push 0x11 pops as 0x11.
REQ-037 SHALL cover: rst_n low mid-burst -> outputs take REQ-024 values asynchronously, and under the macro level_o=0.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package
//   Shared types for the HWPE stream FIFO family.
//   hwpe_stream_fifo_flags_t : occupancy flag bundle {empty, full, almost_full}.
package hwpe_stream_package;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
   } hwpe_stream_fifo_flags_t;

endpackage

// File: rtl/hwpe_stream_fifo_scm.sv
// hwpe_stream_fifo_scm
//   Standard-cell memory behavioural model: 2**ADDR_WIDTH x DATA_WIDTH storage,
//   one write port and one registered read port.
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     ReadEnable/ReadAddr/ReadData      read port; ReadData updates on the edge
//                                       after ReadEnable and holds otherwise
//     WriteEnable/WriteAddr/WriteData   write port; storage updates on the edge
//   Storage and the read data register are not reset; rst_n only blocks
//   accesses while reset is held so nothing in flight lands in the array.
module hwpe_stream_fifo_scm #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ReadEnable,
   input  logic [ADDR_WIDTH-1:0] ReadAddr,
   output logic [DATA_WIDTH-1:0] ReadData,
   input  logic                  WriteEnable,
   input  logic [ADDR_WIDTH-1:0] WriteAddr,
   input  logic [DATA_WIDTH-1:0] WriteData
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (WriteEnable && rst_n) mem[WriteAddr] <= WriteData;
      if (ReadEnable && rst_n)  ReadData <= mem[ReadAddr];
   end

endmodule

// File: rtl/hwpe_stream_fifo_scm_ctrl.sv
// hwpe_stream_fifo_scm_ctrl
//   Valid/ready FIFO controller around one hwpe_stream_fifo_scm instance.
//   Ports:
//     clk, rst_n, clear_i                      clock, async reset, sync flush
//     push_valid_i/push_data_i/push_ready_o    upstream stream
//     pop_valid_o/pop_data_o/pop_ready_i       downstream stream (data straight
//                                              from the SCM read register)
//     empty_o, full_o                          occupancy == 0 / == DEPTH
//   Optional (macro HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN):
//     level_o        occupancy
//     almost_full_o  occupancy >= ALMOST_FULL_THR
module hwpe_stream_fifo_scm_ctrl
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 3,
   parameter int unsigned ALMOST_FULL_THR = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  push_valid_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   output logic                  push_ready_o,
   output logic                  pop_valid_o,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   input  logic                  pop_ready_i,
   output logic                  empty_o,
   output logic                  full_o
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  almost_full_o
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0]   wrPtr, rdPtr;
   logic [ADDR_WIDTH:0]     occupancy;   // push handshake .. pop handshake
   logic [ADDR_WIDTH:0]     unreadCnt;   // written, not yet read-issued
   logic                    popValid;
   logic                    pushHs, popHs, readIssue;
   logic [DATA_WIDTH-1:0]   readData;
   hwpe_stream_fifo_flags_t flags;

   assign flags.empty = (occupancy == '0);
   assign flags.full  = (occupancy == DEPTH);

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
   assign flags.almost_full = (occupancy >= (ADDR_WIDTH+1)'(ALMOST_FULL_THR));
   assign level_o           = occupancy;
   assign almost_full_o     = flags.almost_full;
`else
   localparam int unsigned unusedAlmostFullThr = ALMOST_FULL_THR;
   logic unusedAlmostFull;
   assign flags.almost_full = 1'b0;
   assign unusedAlmostFull  = flags.almost_full;
`endif

   // Ready comes only from registered occupancy: a pop in the same cycle does
   // not open a slot for a push, so the displayed slot can never be rewritten.
   assign pushHs = push_valid_i && !flags.full;
   assign popHs  = popValid && pop_ready_i;

   // unreadCnt is registered, so an entry written this cycle is only read
   // from the next cycle on, after the write has settled in the array.
   assign readIssue = !clear_i && (unreadCnt != '0) && (!popValid || pop_ready_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         unreadCnt <= '0;
         popValid  <= 1'b0;
      end else if (clear_i) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         unreadCnt <= '0;
         popValid  <= 1'b0;
      end else begin
         if (pushHs)    wrPtr <= wrPtr + 1'b1;
         if (readIssue) rdPtr <= rdPtr + 1'b1;
         occupancy <= occupancy + (ADDR_WIDTH+1)'(pushHs) - (ADDR_WIDTH+1)'(popHs);
         unreadCnt <= unreadCnt + (ADDR_WIDTH+1)'(pushHs) - (ADDR_WIDTH+1)'(readIssue);
         if (readIssue)  popValid <= 1'b1;
         else if (popHs) popValid <= 1'b0;
      end
   end

   hwpe_stream_fifo_scm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) i_scm (
      .clk         (clk),
      .rst_n       (rst_n),
      .ReadEnable  (readIssue),
      .ReadAddr    (rdPtr),
      .ReadData    (readData),
      .WriteEnable (pushHs && !clear_i),
      .WriteAddr   (wrPtr),
      .WriteData   (push_data_i)
   );

   assign push_ready_o = !flags.full;
   assign pop_valid_o  = popValid;
   assign pop_data_o   = readData;
   assign empty_o      = flags.empty;
   assign full_o       = flags.full;

endmodule

// File: tb/tb_hwpe_stream_fifo_scm_ctrl.sv
module tb_hwpe_stream_fifo_scm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_i;
   logic        push_valid_i;
   logic [31:0] push_data_i;
   logic        push_ready_o;
   logic        pop_valid_o;
   logic [31:0] pop_data_o;
   logic        pop_ready_i;
   logic        empty_o;
   logic        full_o;
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
   logic [3:0]  level_o;
   logic        almost_full_o;
`endif

   int nTests = 0;
   int nFail  = 0;

   hwpe_stream_fifo_scm_ctrl #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (3),
      .ALMOST_FULL_THR (6)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear_i),
      .push_valid_i (push_valid_i),
      .push_data_i  (push_data_i),
      .push_ready_o (push_ready_o),
      .pop_valid_o  (pop_valid_o),
      .pop_data_o   (pop_data_o),
      .pop_ready_i  (pop_ready_i),
      .empty_o      (empty_o),
      .full_o       (full_o)
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
      ,
      .level_o      (level_o),
      .almost_full_o(almost_full_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic nextCyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear_i = 1'b0; push_valid_i = 1'b0; push_data_i = '0; pop_ready_i = 1'b0;
      #3;
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid_o); end
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL reset_empty: got %b want 1", empty_o); end
      nTests++; if (full_o !== 1'b0) begin nFail++; $display("FAIL reset_full: got %b want 0", full_o); end
      nTests++; if (push_ready_o !== 1'b1) begin nFail++; $display("FAIL reset_push_ready: got %b want 1", push_ready_o); end
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
      nTests++; if (level_o !== 4'd0) begin nFail++; $display("FAIL reset_level: got %0d want 0", level_o); end
      nTests++; if (almost_full_o !== 1'b0) begin nFail++; $display("FAIL reset_almost_full: got %b want 0", almost_full_o); end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nextCyc();
   endtask

   // push in cycle 0 -> pop_valid in cycle 2, empty deasserts in cycle 1
   task automatic test_latency();
      push_valid_i = 1'b1; push_data_i = 32'hA5A5A5A5;
      @(negedge clk);
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL lat_c0_empty: got %b want 1", empty_o); end
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL lat_c0_pop_valid: got %b want 0", pop_valid_o); end
      nextCyc();
      push_valid_i = 1'b0;
      @(negedge clk);
      nTests++; if (empty_o !== 1'b0) begin nFail++; $display("FAIL lat_c1_empty: got %b want 0", empty_o); end
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL lat_c1_pop_valid: got %b want 0", pop_valid_o); end
      nextCyc();
      @(negedge clk);
      nTests++; if (pop_valid_o !== 1'b1) begin nFail++; $display("FAIL lat_c2_pop_valid: got %b want 1", pop_valid_o); end
      nTests++; if (pop_data_o !== 32'hA5A5A5A5) begin nFail++; $display("FAIL lat_c2_data: got %h want a5a5a5a5", pop_data_o); end
      pop_ready_i = 1'b1;
      nextCyc();
      pop_ready_i = 1'b0;
      @(negedge clk);
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL lat_c3_pop_valid: got %b want 0", pop_valid_o); end
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL lat_c3_empty: got %b want 1", empty_o); end
      nextCyc();
   endtask

   // 8 pushes of 0..7 with no pops, then a 9th push is refused
   task automatic test_fill();
      pop_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_valid_i = 1'b1; push_data_i = i;
         @(negedge clk);
         nTests++; if (push_ready_o !== 1'b1) begin nFail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, push_ready_o); end
         nextCyc();
      end
      push_data_i = 32'h99;
      @(negedge clk);
      nTests++; if (full_o !== 1'b1) begin nFail++; $display("FAIL fill_full: got %b want 1", full_o); end
      nTests++; if (push_ready_o !== 1'b0) begin nFail++; $display("FAIL fill_not_ready: got %b want 0", push_ready_o); end
      nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'd0) begin nFail++; $display("FAIL fill_head: got v=%b d=%h want v=1 d=0", pop_valid_o, pop_data_o); end
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
      nTests++; if (level_o !== 4'd8) begin nFail++; $display("FAIL fill_level: got %0d want 8", level_o); end
      nTests++; if (almost_full_o !== 1'b1) begin nFail++; $display("FAIL fill_almost_full: got %b want 1", almost_full_o); end
`endif
      nextCyc();
      @(negedge clk);
      nTests++; if (full_o !== 1'b1 || pop_data_o !== 32'd0) begin nFail++; $display("FAIL fill_hold: got full=%b d=%h want full=1 d=0", full_o, pop_data_o); end
      nextCyc();
   endtask

   // from full, push and pop held high for 20 cycles, then drain
   task automatic test_refill();
      logic [31:0] exp;
      pop_ready_i = 1'b1; push_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_data_i = (i == 0) ? 32'h99 : 32'(100 + i - 1);
         exp = (i < 8) ? 32'(i) : 32'(100 + i - 8);
         @(negedge clk);
         nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== exp) begin nFail++; $display("FAIL refill_pop[%0d]: got v=%b d=%0d want v=1 d=%0d", i, pop_valid_o, pop_data_o, exp); end
         nTests++; if (push_ready_o !== (i != 0)) begin nFail++; $display("FAIL refill_ready[%0d]: got %b want %b", i, push_ready_o, (i != 0)); end
         nextCyc();
      end
      push_valid_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         exp = 32'(112 + i);
         @(negedge clk);
         nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== exp) begin nFail++; $display("FAIL drain_pop[%0d]: got v=%b d=%0d want v=1 d=%0d", i, pop_valid_o, pop_data_o, exp); end
         nextCyc();
      end
      pop_ready_i = 1'b0;
      @(negedge clk);
      nTests++; if (empty_o !== 1'b1 || pop_valid_o !== 1'b0) begin nFail++; $display("FAIL drain_empty: got e=%b v=%b want e=1 v=0", empty_o, pop_valid_o); end
      nextCyc();
   endtask

   // random valid/ready against a queue scoreboard
   task automatic test_random();
      logic [31:0] q[$];
      logic [31:0] exp;
      logic [31:0] held = '0;
      logic        wasStall = 1'b0;
      int          occ = 0;
      int          nPop = 0;
      for (int c = 0; c < 2000 && nPop < 30; c++) begin
         push_valid_i = 1'($urandom_range(0, 1));
         push_data_i  = $urandom();
         pop_ready_i  = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         nTests++; if (push_ready_o !== (occ != 8)) begin nFail++; $display("FAIL rand_push_ready: got %b want %b (occ %0d)", push_ready_o, (occ != 8), occ); end
         if (wasStall) begin
            nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== held) begin nFail++; $display("FAIL rand_stall: got v=%b d=%h want v=1 d=%h", pop_valid_o, pop_data_o, held); end
         end
         if (pop_valid_o && pop_ready_i) begin
            nTests++;
            if (q.size() == 0) begin nFail++; $display("FAIL rand_pop: got d=%h want no pop (scoreboard empty)", pop_data_o); end
            else begin
               exp = q.pop_front();
               if (pop_data_o !== exp) begin nFail++; $display("FAIL rand_pop: got %h want %h", pop_data_o, exp); end
            end
            occ--; nPop++;
         end
         if (push_valid_i && push_ready_o) begin q.push_back(push_data_i); occ++; end
         wasStall = pop_valid_o && !pop_ready_i;
         held     = pop_data_o;
         nextCyc();
      end
      nTests++; if (nPop < 30) begin nFail++; $display("FAIL rand_timeout: got %0d pops want 30", nPop); end
      push_valid_i = 1'b0; pop_ready_i = 1'b1;
      for (int c = 0; c < 40 && q.size() > 0; c++) begin
         @(negedge clk);
         if (pop_valid_o) begin
            exp = q.pop_front();
            nTests++; if (pop_data_o !== exp) begin nFail++; $display("FAIL rand_drain_pop: got %h want %h", pop_data_o, exp); end
         end
         nextCyc();
      end
      @(negedge clk);
      nTests++; if (q.size() != 0) begin nFail++; $display("FAIL rand_drain: got %0d left want 0", q.size()); end
      nTests++; if (empty_o !== 1'b1 || pop_valid_o !== 1'b0) begin nFail++; $display("FAIL rand_empty: got e=%b v=%b want e=1 v=0", empty_o, pop_valid_o); end
      nextCyc();
      pop_ready_i = 1'b0;
   endtask

   // flush with 5 entries, handshakes in the clear cycle are ignored
   task automatic test_clear();
      pop_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_valid_i = 1'b1; push_data_i = 32'h50 + 32'(i);
         nextCyc();
      end
      push_valid_i = 1'b0;
      @(negedge clk);
      nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h50) begin nFail++; $display("FAIL clr_pre: got v=%b d=%h want v=1 d=50", pop_valid_o, pop_data_o); end
      nextCyc();
      clear_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'hDEAD; pop_ready_i = 1'b1;
      nextCyc();
      clear_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
      @(negedge clk);
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL clr_empty: got %b want 1", empty_o); end
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL clr_pop_valid: got %b want 0", pop_valid_o); end
      nextCyc();
      push_valid_i = 1'b1; push_data_i = 32'h11;
      nextCyc();
      push_valid_i = 1'b0;
      nextCyc();
      @(negedge clk);
      nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h11) begin nFail++; $display("FAIL clr_repush: got v=%b d=%h want v=1 d=11", pop_valid_o, pop_data_o); end
      pop_ready_i = 1'b1;
      nextCyc();
      pop_ready_i = 1'b0;
      @(negedge clk);
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL clr_final_empty: got %b want 1", empty_o); end
      nextCyc();
   endtask

   // async reset in the middle of a push burst drops everything
   task automatic test_reset_mid();
      pop_ready_i = 1'b0; push_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_data_i = 32'h60 + 32'(i);
         nextCyc();
      end
      push_data_i = 32'h64;
      nTests++; if (pop_valid_o !== 1'b1 || empty_o !== 1'b0) begin nFail++; $display("FAIL rstm_pre: got v=%b e=%b want v=1 e=0", pop_valid_o, empty_o); end
      #2;
      rst_n = 1'b0;
      #1;
      nTests++; if (pop_valid_o !== 1'b0) begin nFail++; $display("FAIL rstm_pop_valid: got %b want 0", pop_valid_o); end
      nTests++; if (empty_o !== 1'b1) begin nFail++; $display("FAIL rstm_empty: got %b want 1", empty_o); end
      nTests++; if (full_o !== 1'b0) begin nFail++; $display("FAIL rstm_full: got %b want 0", full_o); end
      nTests++; if (push_ready_o !== 1'b1) begin nFail++; $display("FAIL rstm_push_ready: got %b want 1", push_ready_o); end
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_LEVEL_EN
      nTests++; if (level_o !== 4'd0) begin nFail++; $display("FAIL rstm_level: got %0d want 0", level_o); end
`endif
      push_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nextCyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nTests++; if (pop_valid_o !== 1'b0 || empty_o !== 1'b1) begin nFail++; $display("FAIL rstm_dropped[%0d]: got v=%b e=%b want v=0 e=1", i, pop_valid_o, empty_o); end
         nextCyc();
      end
      push_valid_i = 1'b1; push_data_i = 32'h77;
      nextCyc();
      push_valid_i = 1'b0;
      nextCyc();
      @(negedge clk);
      nTests++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h77) begin nFail++; $display("FAIL rstm_repush: got v=%b d=%h want v=1 d=77", pop_valid_o, pop_data_o); end
      nextCyc();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_refill();
      test_random();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
